// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers for param_sync_fifo.
//   cnt_w()     - width of count/pointers (address bits plus wrap bit)
//   is_pow2()   - power-of-two test used for DEPTH
//   params_ok() - elaboration-time legality of DEPTH and thresholds
package fifo_pkg;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int depth, input int afull_th,
                                   input int aempty_th);
    return is_pow2(depth) &&
           (afull_th >= 1) && (afull_th <= depth) &&
           (aempty_th >= 0) && (aempty_th <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port storage, DATA_W x DEPTH.
//   clk   - clock, rising edge
//   rst_n - async active-low reset (read register only; array is not reset)
//   we    - write strobe; waddr/wdata written on the rising edge
//   re    - read strobe; rdata <= mem[raddr] on the rising edge, else holds
//   rdata - registered read data
module fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with occupancy, programmable
// almost-full/almost-empty, registered read data and sticky error flags.
//   clk, rst_n          - clock (rising) and async active-low reset
//   flush               - sync clear of pointers, count, data_valid, errors
//   write_en, data_in   - write request and data (dropped while full)
//   read_en             - read request (dropped while empty)
//   data_out, data_valid- read word, valid one cycle after an accepted read
//   full, empty         - count == DEPTH / count == 0
//   almost_full/_empty  - count >= AFULL_TH / count <= AEMPTY_TH
//   count               - occupancy 0..DEPTH
//   overflow, underflow - sticky: write while full / read while empty
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 4,
  parameter int CNT_W     = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              write_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = CNT_W - 1;
  localparam logic [CNT_W-1:0] AF_LVL = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] AE_LVL = CNT_W'(AEMPTY_TH);

  if (!params_ok(DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_param_err
    $error("param_sync_fifo: DEPTH must be a power of two >= 2 and thresholds in range");
  end

  logic [CNT_W-1:0] wr_ptr, rd_ptr;
  logic             wr_acc, rd_acc;

  // Occupancy falls out of the pointer difference modulo 2*DEPTH, so count
  // and the flags can never disagree within a cycle.
  always_comb begin
    count        = wr_ptr - rd_ptr;
    empty        = (wr_ptr == rd_ptr);
    full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[CNT_W-1] != rd_ptr[CNT_W-1]);
    almost_full  = (count >= AF_LVL);
    almost_empty = (count <= AE_LVL);
    wr_acc       = write_en && !full  && !flush;
    rd_acc       = read_en  && !empty && !flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      data_valid <= rd_acc;
      if (write_en && full)  overflow  <= 1'b1;
      if (read_en  && empty) underflow <= 1'b1;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_param_sync_fifo.sv
module tb_param_sync_fifo;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 16;
  localparam int AFULL_TH  = 12;
  localparam int AEMPTY_TH = 4;
  localparam int CNT_W     = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush, write_en, read_en;
  logic [DATA_W-1:0] data_in, data_out;
  logic              data_valid, full, empty, almost_full, almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow, underflow;

  always #5 clk = ~clk;

  param_sync_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AFULL_TH  (AFULL_TH),
    .AEMPTY_TH (AEMPTY_TH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .write_en     (write_en),
    .data_in      (data_in),
    .read_en      (read_en),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: a queue of stored words plus the observable registers.
  logic [DATA_W-1:0] q[$];
  bit                m_ov, m_un, m_valid;
  logic [DATA_W-1:0] m_dout = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_ov = 0; m_un = 0; m_valid = 0; m_dout = '0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"},        32'(count),        32'(q.size()));
    chk({tag, ".full"},         32'(full),         32'(q.size() == DEPTH));
    chk({tag, ".empty"},        32'(empty),        32'(q.size() == 0));
    chk({tag, ".almost_full"},  32'(almost_full),  32'(q.size() >= AFULL_TH));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(q.size() <= AEMPTY_TH));
    chk({tag, ".overflow"},     32'(overflow),     32'(m_ov));
    chk({tag, ".underflow"},    32'(underflow),    32'(m_un));
    chk({tag, ".data_valid"},   32'(data_valid),   32'(m_valid));
    chk({tag, ".data_out"},     32'(data_out),     32'(m_dout));
  endtask

  // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input bit we, input logic [DATA_W-1:0] din, input bit re,
                      input bit fl, input string tag);
    bit wr_ok, rd_ok;
    @(negedge clk);
    write_en = we; data_in = din; read_en = re; flush = fl;
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
      m_ov = 0; m_un = 0; m_valid = 0;
    end else begin
      wr_ok = we && (q.size() < DEPTH);
      rd_ok = re && (q.size() != 0);
      if (we && !wr_ok) m_ov = 1;
      if (re && !rd_ok) m_un = 1;
      m_valid = rd_ok;
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(din);
    end
    check_model(tag);
  endtask

  typedef struct {
    bit                we;
    logic [DATA_W-1:0] din;
    bit                re;
    bit                fl;
    int                cnt;
    bit                vld;
    logic [DATA_W-1:0] dout;
    bit                un;
  } vec_t;

  vec_t vecs[8];

  initial begin
    rst_n = 1'b0; flush = 1'b0; write_en = 1'b0; read_en = 1'b0; data_in = '0;
    model_reset();

    // Reset state while rst_n is held low.
    @(posedge clk); #1;
    check_model("reset");
    @(negedge clk); rst_n = 1'b1;

    // Directed table: expected values computed by hand.
    vecs[0] = '{1, 8'hA1, 0, 0, 1, 0, 8'h00, 0};
    vecs[1] = '{1, 8'hA2, 0, 0, 2, 0, 8'h00, 0};
    vecs[2] = '{0, 8'h00, 1, 0, 1, 1, 8'hA1, 0};
    vecs[3] = '{1, 8'hA3, 1, 0, 1, 1, 8'hA2, 0};
    vecs[4] = '{0, 8'h00, 0, 0, 1, 0, 8'hA2, 0};
    vecs[5] = '{0, 8'h00, 1, 0, 0, 1, 8'hA3, 0};
    vecs[6] = '{0, 8'h00, 1, 0, 0, 0, 8'hA3, 1};
    vecs[7] = '{1, 8'hEE, 1, 1, 0, 0, 8'hA3, 0};
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].we, vecs[i].din, vecs[i].re, vecs[i].fl, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.cnt", i),  32'(count),      32'(vecs[i].cnt));
      chk($sformatf("tbl%0d.vld", i),  32'(data_valid), 32'(vecs[i].vld));
      chk($sformatf("tbl%0d.dout", i), 32'(data_out),   32'(vecs[i].dout));
      chk($sformatf("tbl%0d.un", i),   32'(underflow),  32'(vecs[i].un));
    end

    // Fill 0x11..0x20, watching almost_full and full thresholds.
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(8'h11 + i), 0, 0, "fill");
      if (i == 10) chk("fill11.almost_full", 32'(almost_full), 0);
      if (i == 11) chk("fill12.almost_full", 32'(almost_full), 1);
      if (i == 14) begin
        chk("fill15.count", 32'(count), 15);
        chk("fill15.full", 32'(full), 0);
      end
    end
    chk("fill16.full", 32'(full), 1);
    chk("fill16.count", 32'(count), 16);

    step(1, 8'hAA, 0, 0, "ovf");
    chk("ovf.overflow", 32'(overflow), 1);
    chk("ovf.count", 32'(count), 16);

    for (int i = 0; i < 16; i++) begin
      step(0, 8'h00, 1, 0, "drain");
      chk($sformatf("drain%0d.dout", i), 32'(data_out), 32'(8'h11 + i));
      chk($sformatf("drain%0d.vld", i), 32'(data_valid), 1);
    end
    chk("drain.empty", 32'(empty), 1);
    chk("drain.overflow_sticky", 32'(overflow), 1);

    // Empty: simultaneous write and read; write lands, read rejected, no bypass.
    step(1, 8'h55, 1, 0, "emptyrw");
    chk("emptyrw.underflow", 32'(underflow), 1);
    chk("emptyrw.count", 32'(count), 1);
    chk("emptyrw.vld", 32'(data_valid), 0);
    step(0, 8'h00, 1, 0, "emptyrw_rd");
    chk("emptyrw_rd.dout", 32'(data_out), 32'h55);
    chk("emptyrw_rd.vld", 32'(data_valid), 1);

    // Full: simultaneous write and read; read returns oldest, write dropped.
    for (int i = 0; i < 16; i++) step(1, 8'(8'h60 + i), 0, 0, "refill");
    step(1, 8'h77, 1, 0, "fullrw");
    chk("fullrw.dout", 32'(data_out), 32'h60);
    chk("fullrw.count", 32'(count), 15);

    // Mixed ops across pointer wrap.
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 0, "wrap");

    // Half-full flush with write_en asserted.
    step(0, 8'h00, 0, 1, "preflush");
    for (int i = 0; i < 8; i++) step(1, 8'(8'h90 + i), 0, 0, "half");
    step(1, 8'hBB, 1, 1, "flush");
    chk("flush.count", 32'(count), 0);
    chk("flush.empty", 32'(empty), 1);
    chk("flush.overflow", 32'(overflow), 0);
    chk("flush.underflow", 32'(underflow), 0);

    // Asynchronous reset in the middle of a burst, between clock edges.
    for (int i = 0; i < 5; i++) step(1, 8'(8'hC0 + i), i[0], 0, "burst");
    @(negedge clk);
    write_en = 1'b1; data_in = 8'hDD;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_model("async_rst");
    write_en = 1'b0;
    @(posedge clk); #1;
    check_model("rst_hold");
    @(negedge clk); rst_n = 1'b1;
    step(1, 8'h3C, 0, 0, "post_rst_wr");
    step(0, 8'h00, 1, 0, "post_rst_rd");
    chk("post_rst.dout", 32'(data_out), 32'h3C);

    // Randomized phases biased towards filling, draining and balanced traffic.
    for (int ph = 0; ph < 6; ph++) begin
      int wp;
      wp = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 15 : 50;
      for (int i = 0; i < 60; i++)
        step(1'($urandom_range(0, 99) < wp), 8'($urandom),
             1'($urandom_range(0, 99) >= wp), 1'($urandom_range(0, 63) == 0), "rand");
    end

    @(negedge clk);
    write_en = 1'b0; read_en = 1'b0; flush = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
